// File: rtl/muldiv_pkg.sv
// Shared definitions for the muldiv unit: FSM state encoding, mul_signed
// field encodings and the Booth iteration-count helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // {a_signed, b_signed}
  localparam logic [1:0] MUL_SS = 2'b11;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_UU = 2'b00;

  // Radix-4 Booth over XLEN bits plus one extra step for the unsigned extension
  function automatic int booth_iters(input int xlen);
    return xlen / 2 + 1;
  endfunction

endpackage

// File: rtl/mul_booth_iter_if.sv
// Request/response bundle between the EXU (master) and mul_booth_iter (slave).
interface mul_booth_iter_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      mul_signed;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  modport master (
    output in_valid, mul_signed, src_a, src_b, flush, out_ready,
    input  in_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  in_valid, mul_signed, src_a, src_b, flush, out_ready,
    output in_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/mul_partial_product.sv
// Radix-4 Booth partial-product cell: decodes a multiplier triplet into a
// partial product p and a carry-in c so that p + c is the selected multiple
// of the multiplicand (0, +A, +2A, -2A, -A), negation done as ~X + 1.
module mul_partial_product #(
  parameter int WIDTH = 128
) (
  input  logic [2:0]       triplet_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] pp_o,
  output logic             neg_o
);

  // Standard Booth recoding of {b[i+1], b[i], b[i-1]}
  always_comb begin
    pp_o  = '0;
    neg_o = 1'b0;
    case (triplet_i)
      3'b001, 3'b010: pp_o = mcand_i;
      3'b011:         pp_o = mcand_i << 1;
      3'b100: begin
        pp_o  = ~(mcand_i << 1);
        neg_o = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_o  = ~mcand_i;
        neg_o = 1'b1;
      end
      default: begin
        pp_o  = '0;
        neg_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier: one partial product per cycle into a
// 2*XLEN accumulator, XLEN/2+1 iterations per operation.
// Optional feature macro: MUL_EARLY_OUT_EN -- a zero operand at accept skips
// to the final (no-op) iteration so the result is ready one cycle later.
module mul_booth_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic           clk,
  input  logic           rst,
  mul_booth_iter_if.slave bus
);

  localparam int N      = booth_iters(XLEN);
  localparam int ITER_W = $clog2(N);
  localparam int PW     = 2 * XLEN;
  localparam int MW     = XLEN + 3;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N - 1);

  state_e              state_q;
  logic [ITER_W-1:0]   iter_q;
  logic [PW-1:0]       acc_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [PW-1:0]       mcand_q;
  logic signed [MW-1:0] mplier_q;

  logic [PW-1:0]       mcand_d;
  logic signed [MW-1:0] mplier_d;
  logic [PW-1:0]       acc_d;
  logic [PW-1:0]       pp;
  logic                pp_c;
  logic                accept;
  logic                zero_op;
  logic                a_ext;
  logic                b_ext;

  assign accept = bus.in_valid && in_ready_q && !bus.flush;
  assign a_ext  = bus.mul_signed[1] & bus.src_a[XLEN-1];
  assign b_ext  = bus.mul_signed[0] & bus.src_b[XLEN-1];

`ifdef MUL_EARLY_OUT_EN
  assign zero_op = (bus.src_a == '0) || (bus.src_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  mul_partial_product #(
    .WIDTH(PW)
  ) u_pp (
    .triplet_i(mplier_q[2:0]),
    .mcand_i  (mcand_q),
    .pp_o     (pp),
    .neg_o    (pp_c)
  );

  // Operand registers: load on accept, shift two bit positions per BUSY cycle.
  // An early-out load clears the multiplier so the single remaining step adds 0.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q + pp + PW'(pp_c);
    if (accept) begin
      mcand_d  = {{XLEN{a_ext}}, bus.src_a};
      mplier_d = zero_op ? '0 : {b_ext, b_ext, bus.src_b, 1'b0};
    end else if (state_q == ST_BUSY) begin
      mcand_d  = mcand_q << 2;
      mplier_d = mplier_q >>> 2;
    end
  end

  // Operand datapath registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  // Control FSM with registered handshake outputs and the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      iter_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= ST_IDLE;
      iter_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_BUSY;
            acc_q      <= '0;
            iter_q     <= zero_op ? ITER_LAST : '0;
            in_ready_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          acc_q <= acc_d;
          if (iter_q == ITER_LAST) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            iter_q <= iter_q + ITER_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          iter_q      <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result_hi = acc_q[PW-1:XLEN];
  assign bus.result_lo = acc_q[XLEN-1:0];

endmodule

// File: tb/tb_mul_booth_iter.sv
// Bench for mul_booth_iter: vector table plus hand-written flush, reset and
// backpressure sequences; expected products held in a scoreboard queue.
module tb_mul_booth_iter;
  import muldiv_pkg::*;

  localparam int XLEN = 64;
  localparam int NIT  = 33;
`ifdef MUL_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = NIT;
`endif

  typedef struct {
    logic [1:0]      s;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    int              lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [2*XLEN-1:0] sb_q[$];
  vec_t tbl[12];

  mul_booth_iter_if #(.XLEN(XLEN)) bus ();

  mul_booth_iter #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*XLEN-1:0] model(input logic [1:0] s,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ea;
    logic [2*XLEN-1:0] eb;
    ea = s[1] ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    eb = s[0] ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic check(input string name, input logic [2*XLEN-1:0] act,
                       input logic [2*XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for in_ready, present one request, push its expectation, accept at the next edge
  task automatic start_op(input logic [1:0] s, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [2*XLEN-1:0] exp,
                          input bit push);
    int k;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_in_ready", 128'(bus.in_ready), 128'(1));
    bus.mul_signed = s;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.in_valid   = 1'b1;
    if (push) sb_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("in_ready_after_accept", 128'(bus.in_ready), 128'(0));
  endtask

  // Count edges after accept until out_valid, then compare against the scoreboard
  task automatic wait_result(input string name, input int exp_lat);
    int lat;
    logic [2*XLEN-1:0] exp;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(exp_lat));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check({name, "_hi"}, 128'(bus.result_hi), 128'(exp[2*XLEN-1:XLEN]));
    check({name, "_lo"}, 128'(bus.result_lo), 128'(exp[XLEN-1:0]));
  endtask

  task automatic do_op(input string name, input vec_t v);
    start_op(v.s, v.a, v.b, {v.hi, v.lo}, 1'b1);
    wait_result(name, v.lat);
    @(posedge clk); #1;
    check({name, "_done_vld"}, 128'(bus.out_valid), 128'(0));
    check({name, "_done_rdy"}, 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    logic [2*XLEN-1:0] m;
    logic [2*XLEN-1:0] held;
    vec_t v;
    int seen;
    n_cmp = 0;
    n_bad = 0;

    tbl[0] = '{MUL_SS, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0, 64'h1, NIT};
    tbl[1] = '{MUL_UU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'h1, NIT};
    tbl[2] = '{MUL_SU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, NIT};
    tbl[3] = '{MUL_SS, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 64'h0, NIT};
    tbl[4] = '{MUL_SS, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, NIT};
    tbl[5] = '{MUL_UU, 64'h0, 64'h1234, 64'h0, 64'h0, ZLAT};
    tbl[6] = '{MUL_UU, 64'h8000_0000_0000_0000, 64'h2, 64'h1, 64'h0, NIT};
    tbl[7] = '{MUL_SU, 64'h5, 64'h8000_0000_0000_0000,
               64'h2, 64'h8000_0000_0000_0000, NIT};
    for (int i = 8; i < 12; i++) begin
      tbl[i].s   = (i % 3 == 0) ? MUL_SS : ((i % 3 == 1) ? MUL_SU : MUL_UU);
      tbl[i].a   = {$urandom, $urandom} | 64'h1;
      tbl[i].b   = {$urandom, $urandom} | 64'h100;
      m          = model(tbl[i].s, tbl[i].a, tbl[i].b);
      tbl[i].hi  = m[2*XLEN-1:XLEN];
      tbl[i].lo  = m[XLEN-1:0];
      tbl[i].lat = NIT;
    end

    bus.in_valid   = 1'b0;
    bus.mul_signed = MUL_UU;
    bus.src_a      = '0;
    bus.src_b      = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
    rst            = 1'b1;
    #12;
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("reset_result", {bus.result_hi, bus.result_lo}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i]);
    end

    // Backpressure: hold out_ready low for five DONE cycles, handshake on the sixth
    bus.out_ready = 1'b0;
    start_op(MUL_SS, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210,
             model(MUL_SS, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210), 1'b1);
    held = model(MUL_SS, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
    wait_result("bp", NIT);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_vld%0d", c), 128'(bus.out_valid), 128'(1));
      check($sformatf("bp_hold_rdy%0d", c), 128'(bus.in_ready), 128'(0));
      check($sformatf("bp_hold_res%0d", c), {bus.result_hi, bus.result_lo}, held);
      @(posedge clk); #1;
    end
    check("bp_cycle6_vld", 128'(bus.out_valid), 128'(1));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_rdy", 128'(bus.in_ready), 128'(1));
    check("bp_release_vld", 128'(bus.out_valid), 128'(0));

    // Flush on the tenth BUSY cycle: no result may appear afterwards
    start_op(MUL_UU, 64'hDEAD_BEEF_0000_0001, 64'h3, '0, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_in_ready", 128'(bus.in_ready), 128'(1));
    check("flush_out_valid", 128'(bus.out_valid), 128'(0));
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_result", 128'(seen), 128'(0));
    v = tbl[4];
    do_op("post_flush", v);

    // Asynchronous reset mid-BUSY: outputs return to reset values without a clock edge
    start_op(MUL_SS, 64'h7, 64'h9, '0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 128'(bus.in_ready), 128'(1));
    check("arst_out_valid", 128'(bus.out_valid), 128'(0));
    check("arst_result", {bus.result_hi, bus.result_lo}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    v = tbl[2];
    do_op("post_reset", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_booth_iter.md
# mul_booth_iter

Iterative radix-4 Booth multiplier that sits directly downstream of the Booth partial-product cell in the muldiv unit. It accepts one XLEN×XLEN multiply per valid/ready handshake. Each cycle it forms one Booth partial product and accumulates it into a 2·XLEN carry-propagate accumulator. It returns the full 2·XLEN product to the EXU, which selects MUL/MULH/MULHSU/MULHU halves.

## Interface
- XLEN, 64, operand width; must be even and ≥ 4.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; high only in IDLE.
- mul_signed  input  2  {a_signed, b_signed}; 11 MULH, 10 MULHSU, 00 MULHU/MUL.
- src_a  input  XLEN  multiplicand.
- src_b  input  XLEN  multiplier.
- flush  input  1  synchronous abort, highest priority.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result_hi  output  XLEN  product bits [2·XLEN-1:XLEN].
- result_lo  output  XLEN  product bits [XLEN-1:0].

## Operation
- States: IDLE, BUSY, DONE; encoding from shared package.
- Accept when in_valid && in_ready. At that edge:
  - multiplicand register ← src_a extended to 2·XLEN (sign-extended if a_signed, else zero-extended).
  - multiplier register ← {2 ext bits, src_b, 1'b0}, XLEN+3 bits (ext = src_b[XLEN-1] if b_signed, else 0).
  - acc ← 0, iter ← 0, state → BUSY.
- N = XLEN/2 + 1 iterations (33 for XLEN=64). The extra iteration covers the unsigned extension.
- Each BUSY cycle:
  - Triplet = multiplier[2:0], decoded with standard radix-4 Booth: 0, +A, +2A, −2A, −A, with −X = ~X + 1.
  - acc ← acc + p + c (mod 2^(2·XLEN)).
  - multiplicand <<= 2, multiplier >>= 2 (arithmetic), iter++.
- When iter == N−1 at an edge, the final add completes and state → DONE.
- DONE: out_valid=1; result_hi/lo = acc halves, held stable. On out_valid && out_ready → IDLE.
- flush, any state: next edge → IDLE, out_valid=0, in-flight result discarded. flush overrides a simultaneous accept or out handshake.
- No in-DONE acceptance: in_ready=0 until back in IDLE (one bubble cycle between ops).
- Reset (any time, including mid-operation): state=IDLE, acc=0, iter=0, so out_valid=0, in_ready=1, result_hi=result_lo=0.

## Timing
- in_ready, out_valid are decoded from state only. There is no combinational path from in_valid or out_ready to them.
- Latency: out_valid first high N cycles after the accept edge (33 @ XLEN=64), early-out excluded.
- Throughput: one op per N+2 cycles minimum with out_ready held high.
- result holds from DONE entry until the handshake; values after leaving DONE are don't-care except after reset (0).
- iter width: $clog2(N).

## Configuration
- MUL_EARLY_OUT_EN defined: if src_a==0 or src_b==0 at accept, go straight to DONE with acc=0. out_valid is then high the cycle after the accept edge.
- Undefined: zero operands take the full N iterations; result is still 0.

## Structure
- Shared package muldiv_pkg holds the state encoding, mul_signed field encodings (MUL_SS=2'b11, MUL_SU=2'b10, MUL_UU=2'b00), and the N = XLEN/2+1 constant function.
- One sub-module: reuse the existing mul_partial_product cell at WIDTH=2·XLEN for triplet decode (p, c). All sequencing and accumulation stay in mul_booth_iter.

## Test plan
- mul_signed=11, a=b=0xFFFF_FFFF_FFFF_FFFF → hi=0, lo=1; out_valid exactly 33 cycles after accept.
- mul_signed=00, a=b=0xFFFF_FFFF_FFFF_FFFF → hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x1.
- mul_signed=10, a=0xFFFF_FFFF_FFFF_FFFF, b=2 → hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFFE. Also mul_signed=11, a=b=0x8000_0000_0000_0000 → hi=0x4000_0000_0000_0000, lo=0.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid, result_hi/lo stable, in_ready=0; handshake on cycle 6 → IDLE next cycle, in_ready=1.
- flush asserted on 10th BUSY cycle → IDLE next edge, no out_valid. A following op 7×(−3) signed → hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFEB. Async rst mid-BUSY → all outputs at reset values immediately.
- src_a=0, src_b=0x1234 → result 0. Latency 1 cycle with MUL_EARLY_OUT_EN, 33 without.
